// File: rtl/sram_cache_nway_pkg.sv
// Shared types and width helpers for the N-way write-through cache.
package sram_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Byte-offset field width of one line (word select plus byte bits).
    function automatic int offWidth(input int lineWords);
        return log2c(lineWords * 4);
    endfunction

    // Set-index field width.
    function automatic int idxWidth(input int sets);
        return (sets > 1) ? log2c(sets) : 1;
    endfunction

    // Round-robin pointer width; a single-way cache still keeps one bit.
    function automatic int ptrWidth(input int ways);
        return (ways > 1) ? log2c(ways) : 1;
    endfunction

    // Word-select field width.
    function automatic int wordSelWidth(input int lineWords);
        return (lineWords > 1) ? log2c(lineWords) : 1;
    endfunction

endpackage

// File: rtl/sram_cache_nway_if.sv
// CPU-side request bus plus SRAM-controller line-fill / write-through bus.
interface sram_cache_nway_if #(parameter int LINE_WORDS = 2);
    logic                     rd_en_in;
    logic                     wr_en_in;
    logic [31:0]              adr_in;
    logic [31:0]              w_data_in;
    logic                     flush_in;
    logic [31:0]              r_data_out;
    logic                     ready_out;
    logic                     mem_rd_en_out;
    logic                     mem_wr_en_out;
    logic [31:0]              mem_adr_out;
    logic [31:0]              mem_w_data_out;
    logic [32*LINE_WORDS-1:0] mem_r_data_in;
    logic                     mem_ready_in;
    logic [31:0]              read_cnt_out;
    logic [31:0]              hit_cnt_out;

    modport slave (
        input  rd_en_in, wr_en_in, adr_in, w_data_in, flush_in,
        input  mem_r_data_in, mem_ready_in,
        output r_data_out, ready_out, mem_rd_en_out, mem_wr_en_out,
        output mem_adr_out, mem_w_data_out, read_cnt_out, hit_cnt_out
    );

    modport master (
        output rd_en_in, wr_en_in, adr_in, w_data_in, flush_in,
        output mem_r_data_in, mem_ready_in,
        input  r_data_out, ready_out, mem_rd_en_out, mem_wr_en_out,
        input  mem_adr_out, mem_w_data_out, read_cnt_out, hit_cnt_out
    );
endinterface

// File: rtl/sram_cache_nway_way.sv
// One cache way: valid bits, tag array, line data array, tag compare.
module sram_cache_way
    import sram_cache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int TAG_W      = 10
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic [idxWidth(SETS)-1:0]           idx_i,
    input  logic [TAG_W-1:0]                    tag_i,
    input  logic [wordSelWidth(LINE_WORDS)-1:0] word_i,
    input  logic                                fill_i,
    input  logic [32*LINE_WORDS-1:0]            line_i,
    input  logic                                wordWr_i,
    input  logic [31:0]                         wData_i,
    output logic                                valid_o,
    output logic                                hit_o,
    output logic [31:0]                         rData_o
);

    logic [SETS-1:0]                  valid_q;
    logic [TAG_W-1:0]                 tag_q  [SETS];
    logic [LINE_WORDS-1:0][31:0]      data_q [SETS];

    assign valid_o = valid_q[idx_i];
    assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign rData_o = data_q[idx_i][word_i];

    // Valid bits are the only state that reset and flush must clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) valid_q <= '0;
        else if (fill_i)      valid_q[idx_i] <= 1'b1;
    end

    // Tag/data storage behaves like plain SRAM: a line install or a single-word update.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= line_i;
        end else if (wordWr_i) begin
            data_q[idx_i][word_i] <= wData_i;
        end
    end

endmodule

// File: rtl/sram_cache_nway.sv
// N-way set-associative write-through, no-write-allocate cache controller.
// Optional hit statistics are built when SRAM_CACHE_STATS_EN is defined.
module sram_cache_nway
    import sram_cache_pkg::*;
#(
    parameter int          WAYS       = 2,
    parameter int          SETS       = 64,
    parameter int          LINE_WORDS = 2,
    parameter int          TAG_W      = 10,
    parameter logic [31:0] ADDR_BASE  = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    sram_cache_nway_if.slave  bus
);

    localparam int OFF  = offWidth(LINE_WORDS);
    localparam int IDXW = idxWidth(SETS);
    localparam int WSW  = wordSelWidth(LINE_WORDS);
    localparam int PTRW = ptrWidth(WAYS);
    localparam int RELW = OFF + IDXW + TAG_W - 2;

    state_e                      state_q, state_d;
    logic                        respRead_q, respRead_d;
    logic                        flush_q, flush_d;
    logic [LINE_WORDS-1:0][31:0] fillLine_q, fillLine_d;
    logic [PTRW-1:0]             ptr_q [SETS];

    logic [RELW-1:0]  rel;
    logic [IDXW-1:0]  idx;
    logic [TAG_W-1:0] tag;
    logic [WSW-1:0]   word;
    logic [WAYS-1:0]  wayValid, wayHit, fillSel;
    logic [31:0]      wayData [WAYS];
    logic [31:0]      hitWord, rData;
    logic [PTRW-1:0]  victim;
    logic             anyHit, ready, flushApply, fillEn, wordWr;

    assign rel    = RELW'((bus.adr_in - ADDR_BASE) >> 2);
    assign word   = (LINE_WORDS > 1) ? rel[0 +: WSW] : '0;
    assign idx    = rel[OFF-2 +: IDXW];
    assign tag    = rel[OFF-2+IDXW +: TAG_W];
    assign anyHit = |wayHit;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        sram_cache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way (
            .clk_i    (clk),
            .rst_i    (rst),
            .clear_i  (flushApply),
            .idx_i    (idx),
            .tag_i    (tag),
            .word_i   (word),
            .fill_i   (fillSel[w]),
            .line_i   (bus.mem_r_data_in),
            .wordWr_i (wordWr && wayHit[w]),
            .wData_i  (bus.w_data_in),
            .valid_o  (wayValid[w]),
            .hit_o    (wayHit[w]),
            .rData_o  (wayData[w])
        );
    end

    // Hit word mux, victim choice (lowest invalid way, else round-robin) and fill one-hot.
    always_comb begin
        hitWord = '0;
        victim  = ptr_q[idx];
        fillSel = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (wayHit[w]) hitWord = hitWord | wayData[w];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!wayValid[w]) victim = PTRW'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            fillSel[w] = fillEn && (victim == PTRW'(w));
        end
    end

    // Controller next-state and per-cycle strobes; a pending flush beats any request in IDLE.
    always_comb begin
        state_d    = state_q;
        respRead_d = respRead_q;
        fillLine_d = fillLine_q;
        ready      = 1'b0;
        rData      = '0;
        flushApply = 1'b0;
        fillEn     = 1'b0;
        wordWr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_q) begin
                    flushApply = 1'b1;
                end else if (bus.wr_en_in) begin
                    state_d    = WRITE;
                    respRead_d = 1'b0;
                end else if (bus.rd_en_in) begin
                    if (anyHit) begin
                        ready = 1'b1;
                        rData = hitWord;
                    end else begin
                        state_d    = FILL;
                        respRead_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (bus.mem_ready_in) begin
                    fillEn     = 1'b1;
                    fillLine_d = bus.mem_r_data_in;
                    state_d    = RESP;
                end
            end
            WRITE: begin
                if (bus.mem_ready_in) begin
                    wordWr  = anyHit;
                    state_d = RESP;
                end
            end
            RESP: begin
                ready   = 1'b1;
                if (respRead_q) rData = fillLine_q[word];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        flush_d = (flush_q && !flushApply) || bus.flush_in;
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            respRead_q <= 1'b0;
            flush_q    <= 1'b0;
            fillLine_q <= '0;
        end else begin
            state_q    <= state_d;
            respRead_q <= respRead_d;
            flush_q    <= flush_d;
            fillLine_q <= fillLine_d;
        end
    end

    // Per-set round-robin pointers: advance on every fill, cleared by reset and flush.
    always_ff @(posedge clk) begin
        if (rst || flushApply) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (fillEn) begin
            ptr_q[idx] <= PTRW'((int'(ptr_q[idx]) + 1) % WAYS);
        end
    end

    assign bus.ready_out      = ready;
    assign bus.r_data_out     = rData;
    assign bus.mem_rd_en_out  = (state_q == FILL);
    assign bus.mem_wr_en_out  = (state_q == WRITE);
    assign bus.mem_adr_out    = (state_q == FILL) ? {bus.adr_in[31:OFF], {OFF{1'b0}}} : bus.adr_in;
    assign bus.mem_w_data_out = bus.w_data_in;

`ifdef SRAM_CACHE_STATS_EN
    logic [31:0] readCnt_q, hitCnt_q;
    logic        readHit, readDone;

    assign readHit  = (state_q == IDLE) && !flush_q && !bus.wr_en_in && bus.rd_en_in && anyHit;
    assign readDone = readHit || ((state_q == RESP) && respRead_q);

    // Free-running statistics counters that wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            readCnt_q <= '0;
            hitCnt_q  <= '0;
        end else begin
            if (readDone) readCnt_q <= readCnt_q + 32'd1;
            if (readHit)  hitCnt_q  <= hitCnt_q + 32'd1;
        end
    end

    assign bus.read_cnt_out = readCnt_q;
    assign bus.hit_cnt_out  = hitCnt_q;
`else
    assign bus.read_cnt_out = '0;
    assign bus.hit_cnt_out  = '0;
`endif

endmodule
